deserializer_task_9: RTL
========================

DESERIALIZER_TASK_9 -- requirements
Module: deserializer_task_9

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 4, giving the idle cycles after i_busy falls before a burst is closed.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port i_data, input, 8, serial byte from upstream serializer.
REQ-005 SHALL have port i_valid, input, 1, i_data qualifier; one byte accepted per cycle when high, no backpressure.
REQ-006 SHALL have port i_busy, input, 1, upstream burst framing, high while the serializer is sending.
REQ-007 SHALL have port i_ready, input, 1, downstream accepts the current output word.
REQ-008 SHALL have port o_data, output, 8 x [4] unpacked array, reassembled word, lane 0 = first byte received.
REQ-009 SHALL have port o_valid, output, 1, o_data holds a word not yet accepted.
REQ-010 SHALL have port o_err_partial, output, 1, one-cycle pulse when a burst closes with 1-3 bytes pending.
REQ-011 SHALL have port o_overflow, output, 1, sticky flag, a completed word was dropped.
REQ-012 SHALL have port o_word_cnt, output, 16, count of words accepted downstream.

Function
REQ-013 SHALL hold a 2-bit lane counter (0..3) selecting the lane register written by each accepted byte.
REQ-014 SHALL increment the lane counter on each accepted byte, wrapping 3->0.
REQ-015 SHALL treat the byte written to lane 3 as word completion, with the four lane bytes pushed as one entry into a 2-entry output FIFO on the following edge.
REQ-016 SHALL assert o_valid exactly 1 cycle after the completing byte's cycle when the FIFO was empty; o_data SHALL be the FIFO head.
REQ-017 SHALL pop the FIFO on a cycle with o_valid=1 and i_ready=1 (handshake); o_data/o_valid SHALL hold stable otherwise.
REQ-018 SHALL, when a push arrives with the FIFO full and no pop that cycle, drop the new word and set o_overflow until reset.
REQ-019 SHALL accept the push and flag no overflow when the FIFO is full and a pop occurs in the same cycle.
REQ-020 SHALL increment o_word_cnt by 1 per handshake, wrapping 0xFFFF->0x0000.
REQ-021 SHALL implement a state machine with states s_IDLE, s_COLLECT and s_DRAIN.
REQ-022 SHALL transition s_IDLE->s_COLLECT when i_busy=1 or i_valid=1.
REQ-023 SHALL transition s_COLLECT->s_DRAIN when i_busy=0, loading a drain timer with DRAIN_CYC.
REQ-024 SHALL, in s_DRAIN, decrement the timer each cycle, reload it on each accepted byte, and return to s_COLLECT with the lane counter kept if i_busy=1.
REQ-025 SHALL transition s_DRAIN->s_IDLE when the timer reaches 0 with no byte that cycle.
REQ-026 SHALL, on that s_DRAIN->s_IDLE transition, pulse o_err_partial for 1 cycle if the lane counter is nonzero, discard the pending bytes and clear the counter to 0.
REQ-027 SHALL accept bytes in every state; a byte arriving on the s_IDLE->s_COLLECT cycle SHALL be written to lane 0.
REQ-028 SHALL leave the output FIFO and o_word_cnt unaffected by burst closure.

Reset
REQ-029 SHALL, while i_rst_n=0 at a rising edge, force state s_IDLE, lane counter 0, drain timer 0 and FIFO empty.
REQ-030 SHALL, under reset, drive o_valid=0, o_data all lanes 0x00, o_err_partial=0, o_overflow=0 and o_word_cnt=0.
REQ-031 SHALL, on reset mid-word, discard the pending bytes with no o_err_partial pulse, and return the first byte after reset release to lane 0.

Verification
REQ-032 SHALL be verified by: i_busy high, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, i_ready=1 -> o_valid high 1 cycle after 0x44, o_data={0x11,0x22,0x33,0x44}, o_word_cnt=1.
REQ-033 SHALL be verified by: i_ready=0, 12 bytes streamed -> words 1-2 held, word 3 dropped, o_overflow=1; then i_ready=1 -> words 1 and 2 delivered in order, o_word_cnt=2.
REQ-034 SHALL be verified by: FIFO full, i_ready=1 on the cycle the 3rd word pushes -> no overflow, all 3 words delivered.
REQ-035 SHALL be verified by: burst of 6 bytes, i_busy falls, no further bytes -> one word out, o_err_partial pulses exactly DRAIN_CYC+1 cycles after the fall, next burst starts at lane 0.
REQ-036 SHALL be verified by: i_busy falls with 2 bytes pending, 2 bytes arrive within the drain window -> word completes, no o_err_partial.
REQ-037 SHALL be verified by: i_rst_n=0 after 3 bytes, then bytes 0xA0-0xA3 -> no partial pulse, o_data={0xA0,0xA1,0xA2,0xA3}.

Source files
------------

// File: rtl/deserializer_task_9.sv
// Byte-to-word deserializer: packs four serial bytes into one word and
// buffers completed words in a 2-entry output FIFO, with burst-close draining.
module deserializer_task_9 #(
    parameter int DRAIN_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_busy,
    input  logic        i_ready,
    output logic [7:0]  o_data [4],
    output logic        o_valid,
    output logic        o_err_partial,
    output logic        o_overflow,
    output logic [15:0] o_word_cnt
);

    localparam logic [1:0] s_IDLE    = 2'd0;
    localparam logic [1:0] s_COLLECT = 2'd1;
    localparam logic [1:0] s_DRAIN   = 2'd2;

    localparam int TW = $clog2(DRAIN_CYC + 2);
    localparam logic [TW-1:0] TMR_LOAD = TW'(DRAIN_CYC);

    logic [1:0]    r_state;
    logic [TW-1:0] r_tmr;
    logic [1:0]    r_lane;
    logic [7:0]    r_byte [3];
    logic          r_err;

    logic [7:0]    r_mem [2][4];
    logic          r_rd;
    logic [1:0]    r_cnt;
    logic          r_ovf;
    logic [15:0]   r_wcnt;

    logic [7:0]    w_word [4];
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_push_ok;

    assign w_word[0] = r_byte[0];
    assign w_word[1] = r_byte[1];
    assign w_word[2] = r_byte[2];
    assign w_word[3] = i_data;

    assign w_push    = i_valid && (r_lane == 2'd3);
    assign w_pop     = o_valid && i_ready;
    assign w_full    = (r_cnt == 2'd2);
    assign w_wr      = r_rd ^ r_cnt[0];
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Byte capture and burst framing
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= s_IDLE;
            r_tmr   <= '0;
            r_lane  <= 2'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < 3; i++) r_byte[i] <= 8'h00;
        end else begin
            r_err <= 1'b0;
            if (i_valid) begin
                if (r_lane != 2'd3) r_byte[r_lane] <= i_data;
                r_lane <= r_lane + 2'd1;
            end
            unique case (r_state)
                s_IDLE: begin
                    if (i_busy || i_valid) r_state <= s_COLLECT;
                end
                s_COLLECT: begin
                    if (!i_busy) begin
                        r_state <= s_DRAIN;
                        r_tmr   <= TMR_LOAD;
                    end
                end
                s_DRAIN: begin
                    if (i_busy) begin
                        r_state <= s_COLLECT;
                    end else if (i_valid) begin
                        r_tmr <= TMR_LOAD;
                    end else if (r_tmr <= TW'(1)) begin
                        // timer hits zero: close burst, drop any partial word
                        r_state <= s_IDLE;
                        r_tmr   <= '0;
                        r_lane  <= 2'd0;
                        r_err   <= (r_lane != 2'd0);
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                default: r_state <= s_IDLE;
            endcase
        end
    end

    // Output FIFO; a push into a full FIFO survives only if the head pops
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd   <= 1'b0;
            r_cnt  <= 2'd0;
            r_ovf  <= 1'b0;
            r_wcnt <= 16'h0000;
            for (int e = 0; e < 2; e++)
                for (int i = 0; i < 4; i++) r_mem[e][i] <= 8'h00;
        end else begin
            if (w_pop) begin
                r_rd   <= ~r_rd;
                r_wcnt <= r_wcnt + 16'h0001;
            end
            if (w_push_ok) begin
                for (int i = 0; i < 4; i++) r_mem[w_wr][i] <= w_word[i];
            end else if (w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_push_ok && !w_pop)      r_cnt <= r_cnt + 2'd1;
            else if (!w_push_ok && w_pop) r_cnt <= r_cnt - 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) o_data[i] = r_mem[r_rd][i];
    end

    assign o_valid       = (r_cnt != 2'd0);
    assign o_err_partial = r_err;
    assign o_overflow    = r_ovf;
    assign o_word_cnt    = r_wcnt;

endmodule
